// File: rtl/key_pkg.sv
// Shared definitions for the key-to-clock-setting controller.
// Mode encodings, the FSM state type and default cycle constants for a 50 MHz clock.
// No ports; imported by the controller.
package key_pkg;

    localparam logic [1:0] MODE_RUN      = 2'b00;
    localparam logic [1:0] MODE_SET_HOUR = 2'b01;
    localparam logic [1:0] MODE_SET_MIN  = 2'b10;

    // Defaults at 50 MHz: 1 s hold, 0.2 s repeat, 10 s timeout, 0.25 s blink half-period.
    localparam int unsigned HOLD_CYCLES_DEF    = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF  = 10_000_000;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 500_000_000;
    localparam int unsigned BLINK_CYCLES_DEF   = 12_500_000;
    localparam int          CNT_W_DEF          = 32;

    typedef enum logic [1:0] {
        ST_RUN      = MODE_RUN,
        ST_SET_HOUR = MODE_SET_HOUR,
        ST_SET_MIN  = MODE_SET_MIN,
        ST_ILLEGAL  = 2'b11
    } mode_e;

endpackage

// File: rtl/key_edge.sv
// Rising-edge (press) detector for one debounced key level.
// Ports: clk, rst_n (async active-low), key (level in), press (high in the cycle a new press is sampled).
// The previous-level register resets to 1 so a key already held at reset release is not a press.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    logic key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key;
        end
    end

    // Formed from the registered previous level; the consumer registers every
    // output on this, so a press sampled at an edge shows up right after that edge.
    assign press = key & ~key_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Turns debounced mode/increment key levels into clock-setting commands.
// Ports: clk, rst_n (async active-low), key_mode/key_inc (levels), mode[1:0],
//        inc_hour/inc_min (1-cycle pulses), set_active, blink. All outputs registered, 1-cycle latency.
module key_mode_ctrl
    import key_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES  = REPEAT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned BLINK_CYCLES   = BLINK_CYCLES_DEF,
    parameter int          CNT_W          = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [1:0] mode,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       set_active,
    output logic       blink
);

    mode_e            state;
    mode_e            state_nxt;
    logic             mode_press;
    logic             inc_press;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] blink_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic [CNT_W-1:0] blink_nxt;
    logic [CNT_W-1:0] rep_thr;
    logic             rep_arm;    // a press was accepted in SET and the key is still held
    logic             rep_phase;  // first repeat already issued; now counting REPEAT_CYCLES
    logic             in_set;
    logic             timeout;
    logic             mode_chg;
    logic             rep_hit;
    logic             inc_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    key_edge u_edge_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_mode),
        .press (mode_press)
    );

    key_edge u_edge_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_inc),
        .press (inc_press)
    );

    always_comb begin
        in_set    = (state == ST_SET_HOUR) || (state == ST_SET_MIN);
        timeout   = in_set && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

        // A mode press beats the timeout; the illegal code falls back to RUN.
        state_nxt = state;
        case (state)
            ST_RUN:      if (mode_press) state_nxt = ST_SET_HOUR;
            ST_SET_HOUR: begin
                if (mode_press)   state_nxt = ST_SET_MIN;
                else if (timeout) state_nxt = ST_RUN;
            end
            ST_SET_MIN:  if (mode_press || timeout) state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
        mode_chg  = (state_nxt != state);

        hold_nxt  = sat_inc(hold_cnt);
        blink_nxt = sat_inc(blink_cnt);
        rep_thr   = rep_phase ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES);
        rep_hit   = rep_arm && key_inc && (hold_nxt == rep_thr);

        // Any mode change (press or timeout) swallows the increment of that cycle.
        inc_ok    = in_set && !mode_chg && (inc_press || rep_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            set_active <= 1'b0;
            blink      <= 1'b0;
            inc_hour   <= 1'b0;
            inc_min    <= 1'b0;
            hold_cnt   <= '0;
            idle_cnt   <= '0;
            blink_cnt  <= '0;
            rep_arm    <= 1'b0;
            rep_phase  <= 1'b0;
        end else begin
            state      <= state_nxt;
            set_active <= (state_nxt != ST_RUN);
            inc_hour   <= inc_ok && (state == ST_SET_HOUR);
            inc_min    <= inc_ok && (state == ST_SET_MIN);

            // Auto-repeat: a mode change disarms until the key is released and pressed again.
            if (!key_inc || mode_chg) begin
                rep_arm   <= 1'b0;
                rep_phase <= 1'b0;
                hold_cnt  <= '0;
            end else if (inc_press && in_set) begin
                rep_arm   <= 1'b1;
                rep_phase <= 1'b0;
                hold_cnt  <= '0;
            end else if (rep_arm) begin
                if (hold_nxt == rep_thr) begin
                    hold_cnt  <= '0;
                    rep_phase <= 1'b1;
                end else begin
                    hold_cnt  <= hold_nxt;
                end
            end

            // Inactivity: cleared in RUN, on SET entry and on any press.
            if ((state_nxt == ST_RUN) || mode_chg || mode_press || inc_press) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= sat_inc(idle_cnt);
            end

            // Blink restarts high on every entry into a SET state.
            if (state_nxt == ST_RUN) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (mode_chg) begin
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_nxt == CNT_W'(BLINK_CYCLES)) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_nxt;
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl with small cycle parameters.
// Table vectors, directed multi-cycle sequences and random stimulus against a reference model.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_key_mode_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int TMO  = 32;
    localparam int BLK  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode;
    logic       key_inc;
    logic [1:0] mode;
    logic       inc_hour;
    logic       inc_min;
    logic       set_active;
    logic       blink;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_mode_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .TIMEOUT_CYCLES (TMO),
        .BLINK_CYCLES   (BLK),
        .CNT_W          (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_mode   (key_mode),
        .key_inc    (key_inc),
        .mode       (mode),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .set_active (set_active),
        .blink      (blink)
    );

    // Reference model: event times in absolute cycle numbers.
    int   m_mode;
    logic m_pkm, m_pki, m_armed;
    int   cyc = 0;
    int   press_cyc = 0;
    int   entry_cyc = 0;
    int   last_act = 0;
    logic e_hour, e_min;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pkm   = 1'b1;
        m_pki   = 1'b1;
        m_armed = 1'b0;
        e_hour  = 1'b0;
        e_min   = 1'b0;
    endtask

    task automatic model_step(input logic km, input logic ki);
        logic mp, ip, tmo, chg, rep, inc;
        int   nxt, d;
        cyc++;
        mp  = km && !m_pkm;
        ip  = ki && !m_pki;
        tmo = (m_mode != 0) && (cyc - last_act == TMO);
        nxt = m_mode;
        if (mp)       nxt = (m_mode + 1) % 3;
        else if (tmo) nxt = 0;
        chg = (nxt != m_mode);
        d   = cyc - press_cyc;
        rep = m_armed && ki && (d >= HOLD) && (((d - HOLD) % REP) == 0);
        inc = (m_mode != 0) && !chg && (ip || rep);
        e_hour = inc && (m_mode == 1);
        e_min  = inc && (m_mode == 2);
        if (!ki || chg) m_armed = 1'b0;
        else if (ip && m_mode != 0) begin
            m_armed   = 1'b1;
            press_cyc = cyc;
        end
        if (mp || ip) last_act = cyc;
        if (chg && nxt != 0) begin
            entry_cyc = cyc;
            last_act  = cyc;
        end
        m_mode = nxt;
        m_pkm  = km;
        m_pki  = ki;
    endtask

    task automatic check_model();
        int eb;
        eb = (m_mode != 0) && ((((cyc - entry_cyc) / BLK) % 2) == 0);
        chk("mode", int'(mode), m_mode);
        chk("inc_hour", int'(inc_hour), int'(e_hour));
        chk("inc_min", int'(inc_min), int'(e_min));
        chk("set_active", int'(set_active), int'(m_mode != 0));
        chk("blink", int'(blink), eb);
        chk("inc_exclusive", int'(inc_hour && inc_min), 0);
    endtask

    task automatic tick(input logic km, input logic ki);
        key_mode = km;
        key_inc  = ki;
        @(posedge clk);
        model_step(km, ki);
        #1;
        check_model();
    endtask

    typedef struct packed {
        logic       km;
        logic       ki;
        logic [1:0] mode;
        logic       ih;
        logic       im;
        logic       sa;
        logic       bl;
    } vec_t;

    vec_t tbl [19];
    int   exp_off [5] = '{0, 8, 12, 16, 20};

    initial begin
        int   first, hour_cnt, found, pulses;
        int   offs[$];
        logic rk, ri;

        //               km ki mode ih im sa bl
        tbl[0]  = 8'b1_0_00_0_0_0_0;  // key_mode held since reset: no press
        tbl[1]  = 8'b1_0_00_0_0_0_0;
        tbl[2]  = 8'b0_0_00_0_0_0_0;
        tbl[3]  = 8'b1_0_01_0_0_1_1;  // genuine press -> SET_HOUR
        tbl[4]  = 8'b1_0_01_0_0_1_1;
        tbl[5]  = 8'b0_0_01_0_0_1_1;
        tbl[6]  = 8'b0_1_01_1_0_1_1;  // inc press -> inc_hour
        tbl[7]  = 8'b0_0_01_0_0_1_0;  // blink toggles 4 cycles after entry
        tbl[8]  = 8'b1_1_10_0_0_1_1;  // simultaneous: mode wins, no pulse
        tbl[9]  = 8'b0_1_10_0_0_1_1;
        tbl[10] = 8'b0_1_10_0_0_1_1;
        tbl[11] = 8'b0_1_10_0_0_1_1;
        tbl[12] = 8'b0_1_10_0_0_1_0;
        tbl[13] = 8'b0_1_10_0_0_1_0;  // still held: no repeat
        tbl[14] = 8'b0_0_10_0_0_1_0;
        tbl[15] = 8'b1_0_00_0_0_0_0;  // third press -> RUN
        tbl[16] = 8'b0_1_00_0_0_0_0;  // inc press in RUN ignored
        tbl[17] = 8'b0_1_00_0_0_0_0;
        tbl[18] = 8'b0_0_00_0_0_0_0;

        rst_n    = 1'b0;
        key_mode = 1'b1;
        key_inc  = 1'b0;
        model_reset();
        #22;
        chk("reset_mode", int'(mode), 0);
        chk("reset_inc_hour", int'(inc_hour), 0);
        chk("reset_inc_min", int'(inc_min), 0);
        chk("reset_set_active", int'(set_active), 0);
        chk("reset_blink", int'(blink), 0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            tick(tbl[i].km, tbl[i].ki);
            chk($sformatf("vec%0d_mode", i), int'(mode), int'(tbl[i].mode));
            chk($sformatf("vec%0d_inc_hour", i), int'(inc_hour), int'(tbl[i].ih));
            chk($sformatf("vec%0d_inc_min", i), int'(inc_min), int'(tbl[i].im));
            chk($sformatf("vec%0d_set_active", i), int'(set_active), int'(tbl[i].sa));
            chk($sformatf("vec%0d_blink", i), int'(blink), int'(tbl[i].bl));
        end

        // Auto-repeat in SET_MIN.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("seq_in_set_min", int'(mode), 2);
        first    = -1;
        hour_cnt = 0;
        for (int j = 0; j <= 20; j++) begin
            tick(1'b0, 1'b1);
            if (inc_min) begin
                if (first < 0) first = j;
                offs.push_back(j - first);
            end
            if (inc_hour) hour_cnt++;
        end
        chk("rep_first_latency", first, 0);
        chk("rep_count", offs.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rep_offset%0d", i), (i < offs.size()) ? offs[i] : -1, exp_off[i]);
        chk("rep_no_hour", hour_cnt, 0);
        for (int j = 0; j < 3; j++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // Plain timeout from SET_HOUR entry.
        tick(1'b1, 1'b0);
        found = -1;
        for (int j = 1; j <= 60; j++) begin
            tick(1'b0, 1'b0);
            if (mode == 2'b00) begin
                found = j;
                break;
            end
        end
        chk("timeout_plain", found, 32);

        // Timeout restarted by an inc press 20 cycles after entry.
        tick(1'b1, 1'b0);
        found = -1;
        for (int j = 1; j <= 90; j++) begin
            tick(1'b0, (j == 20));
            if (mode == 2'b00) begin
                found = j;
                break;
            end
        end
        chk("timeout_restart", found, 52);

        // Reset asserted mid-repeat, released with key_inc still held.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int j = 0; j < 10; j++) tick(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_mode", int'(mode), 0);
        chk("midreset_inc_hour", int'(inc_hour), 0);
        chk("midreset_inc_min", int'(inc_min), 0);
        chk("midreset_set_active", int'(set_active), 0);
        chk("midreset_blink", int'(blink), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        pulses = 0;
        for (int j = 0; j < 12; j++) begin
            tick(1'b0, 1'b1);
            if (inc_hour || inc_min) pulses++;
        end
        chk("post_reset_no_pulse", pulses, 0);

        // Random stimulus against the model.
        rk = 1'b0;
        ri = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(19) == 0) rk = ~rk;
            if ($urandom_range(9) == 0)  ri = ~ri;
            tick(rk, ri);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
